imm_encoder_loader: RTL and testbench

- Inverse of the immediate-generation path. It accepts decoded instruction fields plus a signed 32-bit immediate and packs them into a 32-bit RV32 instruction word (I, S, B or R format).
- It then writes the packed words into instruction memory over a stallable write port, at consecutive word addresses.
- It is used by the test/boot loader to build programs in instruction memory without hand-packing bit fields.

---
 rtl/imm_encoder_loader_pkg.sv | 10 +
 rtl/imm_encoder_loader_imm_pack.sv | 26 ++
 rtl/imm_encoder_loader.sv | 98 +++++++++
 tb/tb_imm_encoder_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_encoder_loader_pkg.sv
// imm_encoder_loader_pkg: shared immediate-format codes, FSM states and range limits
package imm_encoder_loader_pkg;
   typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_R = 2'b11} imm_sel_t;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam int I_MIN = -2048;
   localparam int I_MAX = 2047;
   localparam int B_MIN = -4096;
   localparam int B_MAX = 4094;
   localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/imm_encoder_loader_imm_pack.sv
// imm_pack: packs decoded fields into an RV32 I/S/B/R word and flags out-of-range immediates
module imm_pack
   import imm_encoder_loader_pkg::*;
(
   input  logic [1:0]  IMMSel,
   input  logic [6:0]  Opcode,
   input  logic [4:0]  Rd,
   input  logic [4:0]  Rs1,
   input  logic [4:0]  Rs2,
   input  logic [2:0]  Funct3,
   input  logic [6:0]  Funct7,
   input  logic [31:0] IMM,
   output logic [31:0] Word,
   output logic        RangeErr
);
   logic is_ok;
   logic b_ok;
   assign is_ok = ($signed(IMM) >= I_MIN) && ($signed(IMM) <= I_MAX);
   assign b_ok  = ($signed(IMM) >= B_MIN) && ($signed(IMM) <= B_MAX) && !IMM[0];
   assign Word = (IMMSel == IMM_I) ? {IMM[11:0], Rs1, Funct3, Rd, Opcode} :
                 (IMMSel == IMM_S) ? {IMM[11:5], Rs2, Rs1, Funct3, IMM[4:0], Opcode} :
                 (IMMSel == IMM_B) ? {IMM[12], IMM[10:5], Rs2, Rs1, Funct3, IMM[4:1], IMM[11], Opcode} :
                                     {Funct7, Rs2, Rs1, Funct3, Rd, Opcode};
   assign RangeErr = (IMMSel == IMM_I || IMMSel == IMM_S) ? !is_ok :
                     (IMMSel == IMM_B)                    ? !b_ok  : 1'b0;
endmodule

// File: rtl/imm_encoder_loader.sv
// imm_encoder_loader: encodes instruction fields and streams the words into instruction
// memory at consecutive addresses through a small FIFO and a stallable write port.
module imm_encoder_loader
   import imm_encoder_loader_pkg::*;
#(
   parameter int          ADDR_W     = 32,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_WORD   = NOP
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Start,
   input  logic [ADDR_W-1:0] BaseAddr,
   input  logic [15:0]       Count,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic [1:0]        IMMSel,
   input  logic [6:0]        Opcode,
   input  logic [4:0]        Rd,
   input  logic [4:0]        Rs1,
   input  logic [4:0]        Rs2,
   input  logic [2:0]        Funct3,
   input  logic [6:0]        Funct7,
   input  logic [31:0]       IMM,
   output logic              MemWe,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [31:0]       MemWData,
   input  logic              MemAck,
   output logic              Busy,
   output logic              Done,
   output logic              Err
);
   localparam int PW = $clog2(FIFO_DEPTH);
   state_t      state, state_nx;
   logic [31:0] mem [FIFO_DEPTH];
   logic [PW:0] wr_ptr, rd_ptr;
   logic [15:0] remaining;
   logic [31:0] word;
   logic        range_err, empty, full, push, pop;

   imm_pack u_pack (
      .IMMSel(IMMSel), .Opcode(Opcode), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
      .Funct3(Funct3), .Funct7(Funct7), .IMM(IMM), .Word(word), .RangeErr(range_err)
   );

   assign empty    = wr_ptr == rd_ptr;
   assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign ReqReady = (state == RUN) && !full && (remaining != 16'd0);
   assign push     = ReqValid && ReqReady;
   // the head is loaded when the port is idle or its current word is being acked
   assign pop      = !empty && (!MemWe || MemAck);
   assign Busy     = state != IDLE;
   assign Done     = state == DONE;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (Start) state_nx = (Count != 16'd0) ? RUN : DONE;
         RUN:     if (push && remaining == 16'd1) state_nx = DRAIN;
         DRAIN:   if (empty && !MemWe) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk)
      if (push) mem[wr_ptr[PW-1:0]] <= range_err ? NOP_WORD : word;

   // MemAddr doubles as the session address counter
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         remaining <= '0;
         MemWe     <= 1'b0;
         MemAddr   <= '0;
         MemWData  <= '0;
         Err       <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && Start) begin
            MemAddr   <= BaseAddr & ~ADDR_W'(3);
            remaining <= Count;
            Err       <= 1'b0;
         end
         if (push) begin
            wr_ptr    <= wr_ptr + 1'b1;
            remaining <= remaining - 16'd1;
            if (range_err) Err <= 1'b1;
         end
         if (MemWe && MemAck) MemAddr <= MemAddr + ADDR_W'(4);
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            MemWData <= mem[rd_ptr[PW-1:0]];
         end
         MemWe <= pop || (MemWe && !MemAck);
      end
endmodule

// File: tb/tb_imm_encoder_loader.sv
// tb_imm_encoder_loader: directed sessions; expected writes are queued at request
// acceptance and a negedge monitor compares them against the memory write port.
module tb_imm_encoder_loader;
   logic        Clk = 1'b0, Rst_n = 1'b0, Start = 1'b0, ReqValid = 1'b0, MemAck = 1'b1;
   logic [31:0] BaseAddr = '0, IMM = '0;
   logic [15:0] Count = '0;
   logic [1:0]  IMMSel = '0;
   logic [6:0]  Opcode = '0, Funct7 = '0;
   logic [4:0]  Rd = '0, Rs1 = '0, Rs2 = '0;
   logic [2:0]  Funct3 = '0;
   logic        ReqReady, MemWe, Busy, Done, Err;
   logic [31:0] MemAddr, MemWData;

   int          checks = 0, errors = 0, writes = 0;
   logic [63:0] exp_q[$];
   logic [31:0] exp_addr = '0, pend = '0;

   always #5 Clk = ~Clk;

   imm_encoder_loader dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .BaseAddr(BaseAddr), .Count(Count),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .IMMSel(IMMSel), .Opcode(Opcode),
      .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Funct3(Funct3), .Funct7(Funct7), .IMM(IMM),
      .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemAck(MemAck),
      .Busy(Busy), .Done(Done), .Err(Err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // every presented write must match the queue head, also while stalled
   always @(negedge Clk)
      if (Rst_n && MemWe) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", MemAddr, MemWData);
         end else begin
            chk("wr_addr", MemAddr, exp_q[0][63:32]);
            chk("wr_data", MemWData, exp_q[0][31:0]);
            if (MemAck) begin
               void'(exp_q.pop_front());
               writes++;
            end
         end
      end

   task automatic chk_idle(input string tag);
      chk({tag, "_ready"}, {31'b0, ReqReady}, 32'd0);
      chk({tag, "_we"}, {31'b0, MemWe}, 32'd0);
      chk({tag, "_addr"}, MemAddr, 32'd0);
      chk({tag, "_wdata"}, MemWData, 32'd0);
      chk({tag, "_busy"}, {31'b0, Busy}, 32'd0);
      chk({tag, "_done"}, {31'b0, Done}, 32'd0);
      chk({tag, "_err"}, {31'b0, Err}, 32'd0);
   endtask

   task automatic start(input logic [31:0] base, input logic [15:0] cnt, input bit ignored);
      @(negedge Clk);
      Start = 1'b1;
      BaseAddr = base;
      Count = cnt;
      if (!ignored) exp_addr = base & ~32'h3;
      @(negedge Clk);
      Start = 1'b0;
   endtask

   task automatic set_req(input logic [1:0] sel, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] w);
      @(negedge Clk);
      IMMSel = sel; Opcode = op; Rd = rd; Rs1 = rs1; Rs2 = rs2;
      Funct3 = f3; Funct7 = f7; IMM = imm; pend = w;
      ReqValid = 1'b1;
   endtask

   task automatic accept();
      int n = 0;
      while (!ReqReady && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (!ReqReady) begin
         checks++;
         errors++;
         $display("FAIL req_accept: got ReqReady=0 for %0d cycles expected 1", n);
         ReqValid = 1'b0;
      end else begin
         exp_q.push_back({exp_addr, pend});
         exp_addr += 32'd4;
         @(posedge Clk);
         #1 ReqValid = 1'b0;
      end
   endtask

   task automatic send(input logic [1:0] sel, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] w);
      set_req(sel, op, rd, rs1, rs2, f3, f7, imm, w);
      accept();
   endtask

   task automatic wait_done(input logic exp_err, input int budget);
      int n = 0;
      while (!Done && n < budget) begin
         @(negedge Clk);
         n++;
      end
      checks++;
      if (!Done) begin
         errors++;
         $display("FAIL done_timeout: got Done=0 after %0d cycles expected 1", n);
      end else begin
         chk("done_err", {31'b0, Err}, {31'b0, exp_err});
         chk("done_pending", exp_q.size(), 32'd0);
         chk("done_busy", {31'b0, Busy}, 32'd1);
         @(negedge Clk);
         chk("done_pulse", {31'b0, Done}, 32'd0);
         chk("idle_busy", {31'b0, Busy}, 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      int n;
      repeat (3) @(negedge Clk);
      chk_idle("reset");
      #2 Rst_n = 1'b1;

      start(32'h100, 16'd1, 1'b0);
      chk("run_busy", {31'b0, Busy}, 32'd1);
      chk("run_ready", {31'b0, ReqReady}, 32'd1);
      send(2'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h20, 32'hFFFF_FFFF, 32'hFFF1_0093);
      wait_done(1'b0, 20);

      start(32'h2000, 16'd2, 1'b0);
      send(2'd1, 7'h23, 5'd7, 5'd2, 5'd3, 3'd2, 7'd0, 32'd8, 32'h0031_2423);
      send(2'd2, 7'h63, 5'd9, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3);
      wait_done(1'b0, 20);

      start(32'h300, 16'd3, 1'b0);
      send(2'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0000_0013);
      send(2'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h0000_0013);
      send(2'd0, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'd2047, 32'h7FF3_0293);
      wait_done(1'b1, 20);

      @(posedge Clk);
      #1 MemAck = 1'b0;
      start(32'h400, 16'd4, 1'b0);
      send(2'd3, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h55, 32'h0020_81B3);
      send(2'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0093);
      send(2'd1, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'd8, 32'h0031_2423);
      set_req(2'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         chk("bp_ready", {31'b0, ReqReady}, 32'd0);
      end
      @(posedge Clk);
      #1 MemAck = 1'b1;
      accept();
      wait_done(1'b0, 30);

      w0 = writes;
      start(32'h500, 16'd0, 1'b0);
      wait_done(1'b0, 1);
      chk("cnt0_writes", writes, w0);

      start(32'h600, 16'd2, 1'b0);
      send(2'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0093);
      start(32'h900, 16'd0, 1'b1);
      chk("ign_busy", {31'b0, Busy}, 32'd1);
      chk("ign_done", {31'b0, Done}, 32'd0);
      send(2'd1, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'd8, 32'h0031_2423);
      wait_done(1'b0, 20);

      start(32'hFFFF_FFFE, 16'd2, 1'b0);
      send(2'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093);
      send(2'd3, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h4020_81B3);
      wait_done(1'b0, 20);

      @(posedge Clk);
      #1 MemAck = 1'b0;
      start(32'h700, 16'd2, 1'b0);
      send(2'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0093);
      n = 0;
      while (!MemWe && n < 10) begin
         @(negedge Clk);
         n++;
      end
      chk("rst_pre_we", {31'b0, MemWe}, 32'd1);
      #2 Rst_n = 1'b0;
      #1 chk_idle("midrst");
      exp_q.delete();
      @(negedge Clk);
      @(negedge Clk);
      #2 Rst_n = 1'b1;
      MemAck = 1'b1;
      @(negedge Clk);
      chk_idle("postrst");

      start(32'h800, 16'd1, 1'b0);
      send(2'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0093);
      wait_done(1'b0, 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
